// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC sample scheduler: FSM state encoding,
// ADC command op codes and channel addresses.
// Optional build macro used by the scheduler: ADC_SCHED_MINMAX_EN.
package adc_sched_pkg;

    // FSM state encoding; also exported on the debug port of the top level.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADC_RST = 4'd1,
        ST_ISSUE   = 4'd2,
        ST_WAIT_LO = 4'd3,
        ST_WAIT_HI = 4'd4,
        ST_SEL_A   = 4'd5,
        ST_CAP_A   = 4'd6,
        ST_SEL_B   = 4'd7,
        ST_CAP_B   = 4'd8,
        ST_ACC     = 4'd9,
        ST_GAP     = 4'd10,
        ST_ABORT   = 4'd11,
        ST_DONE    = 4'd12
    } state_t;

    // ADC command op codes (bit0 reset, bit1 convert).
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_RST  = 4'b0001;
    localparam logic [3:0] OP_CONV = 4'b0010;

    // Channel select addresses; only bit0 is decoded by the ADC.
    localparam logic [7:0] CH_A = 8'd0;
    localparam logic [7:0] CH_B = 8'd1;

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Command/readback port between the sample scheduler and the dual-channel
// ADC interface.
//
// Handshake: a command is valid for exactly the cycle in which adc_cs=1;
// adc_op and adc_addr are qualified by adc_cs and there is no back-pressure
// on a command. adc_rdy=1 means the ADC is idle; after a convert command it
// falls (possibly one cycle late) and rises again when results are ready.
// adc_data reflects the channel selected by the most recent adc_addr.
interface adc_sample_scheduler_if #(
    parameter int DATA_W = 14
);
    logic              adc_cs;
    logic [3:0]        adc_op;
    logic [7:0]        adc_addr;
    logic              adc_rdy;
    logic [DATA_W-1:0] adc_data;

    // Scheduler side: issues commands, observes ready and readback.
    modport master (
        output adc_cs,
        output adc_op,
        output adc_addr,
        input  adc_rdy,
        input  adc_data
    );

    // ADC side: receives commands, returns ready and readback.
    modport slave (
        input  adc_cs,
        input  adc_op,
        input  adc_addr,
        output adc_rdy,
        output adc_data
    );
endinterface

// File: rtl/adc_sched_watchdog.sv
// Loadable saturating up-counter with a terminal flag (count >= term).
// Used both as the issue-to-issue period counter and as the conversion
// timeout watchdog.
module adc_sched_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt;

    // Load has priority over increment; increment stops at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt >= term);

endmodule

// File: rtl/adc_sample_scheduler.sv
// ADC sample scheduler: runs a burst of dual-channel conversions at a fixed
// issue-to-issue period, accumulating channel A and B into per-channel sums.
// Host side is a start/busy/done handshake with sticky fault flags.
// Optional build macro: ADC_SCHED_MINMAX_EN adds per-channel min/max outputs.
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int CNT_W   = 8,
    parameter int PER_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic [PER_W-1:0]        period,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic                    overrun,
    output logic [DATA_W+CNT_W-1:0] sum_a,
    output logic [DATA_W+CNT_W-1:0] sum_b,
    output logic [CNT_W-1:0]        count,
`ifdef ADC_SCHED_MINMAX_EN
    output logic [DATA_W-1:0]       min_a,
    output logic [DATA_W-1:0]       max_a,
    output logic [DATA_W-1:0]       min_b,
    output logic [DATA_W-1:0]       max_b,
`endif
    output state_t                  dbg_state,
    adc_sample_scheduler_if.master  adc
);
    localparam int                WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_TERM = WD_W'(TIMEOUT);

    state_t                  state;
    logic [CNT_W-1:0]        n_q;
    logic [PER_W-1:0]        period_m1_q;
    logic [DATA_W-1:0]       sample_a;
    logic [DATA_W-1:0]       sample_b;
    logic [DATA_W+CNT_W-1:0] sum_a_q;
    logic [DATA_W+CNT_W-1:0] sum_b_q;
    logic [CNT_W-1:0]        count_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    timeout_q;
    logic                    overrun_q;
    logic                    cs_q;
    logic [3:0]              op_q;
    logic [7:0]              addr_q;
`ifdef ADC_SCHED_MINMAX_EN
    logic [DATA_W-1:0]       min_a_q;
    logic [DATA_W-1:0]       max_a_q;
    logic [DATA_W-1:0]       min_b_q;
    logic [DATA_W-1:0]       max_b_q;
`endif

    logic pc_load;
    logic pc_tc;
    logic wd_load;
    logic wd_inc;
    logic wd_tc;
    logic waiting;
    logic stop_ok;

    assign waiting = (state == ST_WAIT_LO) || (state == ST_WAIT_HI);

    // Both counters restart in the ISSUE cycle. The period counter then
    // holds the number of cycles elapsed since the issue, so GAP leaves when
    // it reaches period-1 and the next ISSUE lands exactly period cycles
    // after the previous one. The watchdog holds the ordinal of the current
    // wait cycle, so its terminal flag fires in wait cycle number TIMEOUT.
    assign pc_load = (state == ST_ISSUE);
    assign wd_load = (state == ST_ISSUE);
    assign wd_inc  = waiting;

    // A stop is honoured anywhere in an active burst except while the burst
    // is already being torn down.
    assign stop_ok = stop && (state != ST_IDLE) && (state != ST_DONE) &&
                     (state != ST_ABORT);

    adc_sched_watchdog #(.W(PER_W)) u_period_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (PER_W'(1)),
        .inc      (1'b1),
        .term     (period_m1_q),
        .tc       (pc_tc)
    );

    adc_sched_watchdog #(.W(WD_W)) u_timeout_wd (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .load_val (WD_W'(1)),
        .inc      (wd_inc),
        .term     (WD_TERM),
        .tc       (wd_tc)
    );

    // Sequencer FSM with registered ADC command and host outputs; a command
    // is driven on the edge that enters its state so it is visible for
    // exactly the cycle spent in that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            n_q         <= '0;
            period_m1_q <= '0;
            sample_a    <= '0;
            sample_b    <= '0;
            sum_a_q     <= '0;
            sum_b_q     <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            cs_q        <= 1'b0;
            op_q        <= OP_NOP;
            addr_q      <= CH_A;
`ifdef ADC_SCHED_MINMAX_EN
            min_a_q     <= '1;
            max_a_q     <= '0;
            min_b_q     <= '1;
            max_b_q     <= '0;
`endif
        end else begin
            cs_q   <= 1'b0;
            op_q   <= OP_NOP;
            done_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q         <= n_samples;
                        period_m1_q <= (period == '0) ? '0 : period - 1'b1;
                        sum_a_q     <= '0;
                        sum_b_q     <= '0;
                        count_q     <= '0;
                        timeout_q   <= 1'b0;
                        overrun_q   <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef ADC_SCHED_MINMAX_EN
                        min_a_q     <= '1;
                        max_a_q     <= '0;
                        min_b_q     <= '1;
                        max_b_q     <= '0;
`endif
                        state       <= ST_ADC_RST;
                        cs_q        <= 1'b1;
                        op_q        <= OP_RST;
                    end
                end

                ST_ADC_RST: begin
                    if (n_q == '0) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_ISSUE;
                        cs_q  <= 1'b1;
                        op_q  <= OP_CONV;
                    end
                end

                ST_ISSUE: begin
                    state <= ST_WAIT_LO;
                end

                // rdy may still read 1 in the cycle after the issue, so a
                // falling edge must be seen before a rising one counts.
                ST_WAIT_LO: begin
                    if (wd_tc) begin
                        timeout_q <= 1'b1;
                        state     <= ST_ABORT;
                        cs_q      <= 1'b1;
                        op_q      <= OP_RST;
                    end else if (!adc.adc_rdy) begin
                        state <= ST_WAIT_HI;
                    end
                end

                ST_WAIT_HI: begin
                    if (wd_tc) begin
                        timeout_q <= 1'b1;
                        state     <= ST_ABORT;
                        cs_q      <= 1'b1;
                        op_q      <= OP_RST;
                    end else if (adc.adc_rdy) begin
                        state  <= ST_SEL_A;
                        cs_q   <= 1'b1;
                        addr_q <= CH_A;
                    end
                end

                ST_SEL_A: begin
                    state <= ST_CAP_A;
                end

                ST_CAP_A: begin
                    sample_a <= adc.adc_data;
                    state    <= ST_SEL_B;
                    cs_q     <= 1'b1;
                    addr_q   <= CH_B;
                end

                ST_SEL_B: begin
                    state <= ST_CAP_B;
                end

                ST_CAP_B: begin
                    sample_b <= adc.adc_data;
                    state    <= ST_ACC;
                end

                // Sums are DATA_W+CNT_W wide, so even a maximum-length burst
                // of full-scale samples cannot wrap.
                ST_ACC: begin
                    sum_a_q <= sum_a_q + {{CNT_W{1'b0}}, sample_a};
                    sum_b_q <= sum_b_q + {{CNT_W{1'b0}}, sample_b};
                    count_q <= count_q + 1'b1;
`ifdef ADC_SCHED_MINMAX_EN
                    if (sample_a < min_a_q) min_a_q <= sample_a;
                    if (sample_a > max_a_q) max_a_q <= sample_a;
                    if (sample_b < min_b_q) min_b_q <= sample_b;
                    if (sample_b > max_b_q) max_b_q <= sample_b;
`endif
                    if ((count_q + 1'b1) == n_q) begin
                        state <= ST_DONE;
                    end else begin
                        // The period counter will be one higher in GAP;
                        // already at the limit here means GAP is entered
                        // beyond the requested period.
                        if (pc_tc) begin
                            overrun_q <= 1'b1;
                        end
                        state <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (pc_tc) begin
                        state <= ST_ISSUE;
                        cs_q  <= 1'b1;
                        op_q  <= OP_CONV;
                    end
                end

                ST_ABORT: begin
                    state <= ST_DONE;
                end

                ST_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Host abort overrides whatever transition the state chose; the
            // address is left untouched so it still holds its last value.
            if (stop_ok) begin
                state  <= ST_ABORT;
                cs_q   <= 1'b1;
                op_q   <= OP_RST;
                addr_q <= addr_q;
            end
        end
    end

    // Output mapping.
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign overrun     = overrun_q;
    assign sum_a       = sum_a_q;
    assign sum_b       = sum_b_q;
    assign count       = count_q;
    assign dbg_state   = state;
    assign adc.adc_cs   = cs_q;
    assign adc.adc_op   = op_q;
    assign adc.adc_addr = addr_q;
`ifdef ADC_SCHED_MINMAX_EN
    assign min_a = min_a_q;
    assign max_a = max_a_q;
    assign min_b = min_b_q;
    assign max_b = max_b_q;
`endif

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
Sequencer that owns the dual-channel 14-bit ADC interface command port (cs/op/addr, rdy, data_out) and runs a programmed burst of conversions at a fixed sample period. For each sample it reads channel A and channel B and accumulates them into per-channel sums. It gives the host a start/busy/done handshake plus fault flags, and sits between the host register map and the ADC interface.

Parameters:
DATA_W, 14, ADC sample width
CNT_W, 8, sample-count width (max burst 2^CNT_W-1)
PER_W, 16, sample-period counter width in clk cycles
TIMEOUT, 1023, max cycles allowed in WAIT_LO plus WAIT_HI before fault

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; ignored unless busy=0
stop  in  1  one-cycle pulse; aborts an active burst
n_samples  in  CNT_W  burst length; sampled on start
period  in  PER_W  issue-to-issue spacing in cycles; sampled on start
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end (normal, abort or fault)
timeout_err  out  1  sticky; cleared on next accepted start
overrun  out  1  sticky; a conversion exceeded period; cleared on start
sum_a  out  DATA_W+CNT_W  channel A accumulator
sum_b  out  DATA_W+CNT_W  channel B accumulator
count  out  CNT_W  completed samples in current/last burst
adc_cs  out  1  ADC command strobe
adc_op  out  4  ADC op: bit0 reset, bit1 convert
adc_addr  out  8  ADC address; bit0 selects channel (0=A, 1=B)
adc_rdy  in  1  ADC idle/ready
adc_data  in  DATA_W  ADC readback for the selected channel

Behaviour:
- Reset: state IDLE; busy=0, done=0, timeout_err=0, overrun=0, sums=0, count=0, adc_cs=0, adc_op=0, adc_addr=0.
- adc_cs/op/addr are registered. Outside the listed command cycles, adc_cs=0, adc_op=0 and adc_addr holds its value.
- IDLE: on start, latch n_samples/period, clear sums/count/flags, set busy, go to ADC_RST.
- ADC_RST: one cycle with adc_cs=1, op=4'b0001. If latched n_samples==0, go to DONE; otherwise go to ISSUE.
- ISSUE: one cycle with adc_cs=1, op=4'b0010. Period counter loads 1. Watchdog clears.
- WAIT_LO: wait for adc_rdy==0. This guards against the stale rdy=1 in the cycle after issue.
- WAIT_HI: wait for adc_rdy==1.
- Watchdog: counts every cycle spent in WAIT_LO+WAIT_HI. Reaching TIMEOUT sets timeout_err and goes to ABORT.
- SEL_A: adc_cs=1, op=0, addr=0. CAP_A: register adc_data into sample_a.
- SEL_B: adc_cs=1, op=0, addr=1. CAP_B: register adc_data.
- ACC: sum_a+=zero-extended sample_a; sum_b+=sample_b; count+=1. No overflow is possible at max count.
- After ACC: if count==n_samples go to DONE; otherwise go to GAP.
- GAP: wait until period counter >= period, then go to ISSUE.
  - Period counter increments every cycle from ISSUE and saturates.
  - If the counter already exceeds period on entry, set overrun and issue next cycle.
  - period 0 or 1 means back-to-back.
- Issue-to-issue spacing = max(period, conversion + 7 cycles).
- ABORT: one cycle adc_cs=1, op=4'b0001, then go to DONE.
- stop in any non-IDLE state except DONE goes to ABORT next cycle. Sums and count keep their partial values.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while busy is ignored.
- start and stop in the same IDLE cycle: start wins, stop is ignored.
- Async rst mid-burst returns to reset values immediately. No ADC reset command is emitted.

Optional Feature:
ADC_SCHED_MINMAX_EN: adds outputs min_a, max_a, min_b, max_b (DATA_W each).
- Initialised to all-ones (min) and 0 (max) on accepted start.
- Updated in ACC together with the sums.
- With n_samples=0, they keep their init values.
- Without the macro, these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
Shared package adc_sched_pkg holds:
- state encoding localparams
- ADC op codes: OP_RST=4'b0001, OP_CONV=4'b0010, OP_NOP=4'b0000
- channel addresses: CH_A=0, CH_B=1
One sub-module: adc_sched_watchdog, a loadable saturating counter with terminal flag, instanced for the period counter and the timeout watchdog.

Test Plan:
- Bench stub: drops rdy 1 cycle after op=2, raises it 20 cycles later, returns A=100+k / B=8000+k per sample k.
- n_samples=4, period=50 -> 4 issues exactly 50 cycles apart; sum_a=406, sum_b=32006, count=4, one done pulse, overrun=0.
- n_samples=3, period=10 (< conversion) -> back-to-back issues; overrun=1; sums correct; count=3.
- n_samples=0 -> exactly one op=1 command, no op=2, done 3 cycles after start, sums=0.
- Stub never raises rdy, TIMEOUT=1023 -> timeout_err=1 after 1023 wait cycles, op=1 emitted, done pulse, count=0.
- stop after the 2nd ACC of a 10-sample burst -> ABORT with op=1, count=2, partial sums held; next start clears flags and sums.
- rst asserted in WAIT_HI -> all outputs at reset values in the same cycle.
- start during busy has no effect.
